// File: rtl/pc_sequencer.sv
// pc_sequencer
//    Program-counter register and next-PC selector for the fetch path.
//    It supports the MIPS single-instruction branch delay slot: a redirect
//    seen in RUN is saved, one delay-slot fetch (pc + 4) is issued, and then
//    the saved target is loaded. A misaligned register-jump target
//    redirects to EXC_VECTOR instead.
//
// Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    stall          freeze pc/state/target; requests ignored, pulses 0
//    jump_valid     absolute jump request (j/jal)
//    jump_target    jump target {pc_upper, index, 2'b00}; [1:0] forced to 0
//    branch_valid   taken conditional branch
//    branch_offset  signed word offset relative to pc + 4
//    jr_valid       register jump request (jr/jalr)
//    jr_target      register value used as jump target
//    pc             current fetch address (registered)
//    pc_plus4       pc + 4 modulo 2^32 (combinational)
//    pc_upper       pc_plus4[31:28] for the jump-address former
//    in_delay_slot  current pc is a delay-slot fetch (registered)
//    misalign_err   one-cycle pulse after a misaligned jr is accepted
//    slot_violation one-cycle pulse after a request arrives in the delay slot
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        branch_valid,
   input  logic [15:0] branch_offset,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [3:0]  pc_upper,
   output logic        in_delay_slot,
   output logic        misalign_err,
   output logic        slot_violation
);

   typedef enum logic {RUN, SLOT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic        misalign_q, misalign_d;
   logic        slot_viol_q, slot_viol_d;

   logic [31:0] pc_plus4_w;
   logic [31:0] branch_tgt_w;
   logic        req_any_w;
   logic        jr_misaligned_w;
   logic [31:0] sel_target_w;

   assign pc_plus4_w      = pc_q + 32'd4;
   assign branch_tgt_w    = pc_plus4_w + {{14{branch_offset[15]}}, branch_offset, 2'b00};
   assign req_any_w       = jr_valid | jump_valid | branch_valid;
   assign jr_misaligned_w = jr_valid & (jr_target[1:0] != 2'b00);

   // Priority jr > jump > branch; losers are dropped without notice.
   always_comb begin
      sel_target_w = branch_tgt_w;
      if (jr_valid) begin
         sel_target_w = jr_misaligned_w ? EXC_VECTOR : jr_target;
      end else if (jump_valid) begin
         sel_target_w = {jump_target[31:2], 2'b00};
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      target_d    = target_q;
      misalign_d  = 1'b0;
      slot_viol_d = 1'b0;
      if (!stall) begin
         case (state_q)
            RUN: begin
               if (req_any_w) begin
                  misalign_d = jr_misaligned_w;
                  if (DELAY_SLOT) begin
                     // Issue the delay-slot fetch now, redirect afterwards.
                     target_d = sel_target_w;
                     pc_d     = pc_plus4_w;
                     state_d  = SLOT;
                  end else begin
                     pc_d = sel_target_w;
                  end
               end else begin
                  pc_d = pc_plus4_w;
               end
            end
            SLOT: begin
               // Requests in the slot are illegal: ignored but reported.
               pc_d        = target_q;
               state_d     = RUN;
               slot_viol_d = req_any_w;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         target_q    <= 32'h0000_0000;
         misalign_q  <= 1'b0;
         slot_viol_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         target_q    <= target_d;
         misalign_q  <= misalign_d;
         slot_viol_q <= slot_viol_d;
      end
   end

   assign pc             = pc_q;
   assign pc_plus4       = pc_plus4_w;
   assign pc_upper       = pc_plus4_w[31:28];
   assign in_delay_slot  = (state_q == SLOT);
   assign misalign_err   = misalign_q;
   assign slot_violation = slot_viol_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        branch_valid;
   logic [15:0] branch_offset;
   logic        jr_valid;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [3:0]  pc_upper;
   logic        in_delay_slot;
   logic        misalign_err;
   logic        slot_violation;

   // Second instance without delay slot, driven separately
   logic        z_stall;
   logic        z_jump_valid;
   logic [31:0] z_jump_target;
   logic        z_jr_valid;
   logic [31:0] z_jr_target;
   logic [31:0] z_pc;
   logic [31:0] z_pc_plus4;
   logic [3:0]  z_pc_upper;
   logic        z_in_delay_slot;
   logic        z_misalign_err;
   logic        z_slot_violation;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .branch_valid(branch_valid), .branch_offset(branch_offset),
      .jr_valid(jr_valid), .jr_target(jr_target),
      .pc(pc), .pc_plus4(pc_plus4), .pc_upper(pc_upper),
      .in_delay_slot(in_delay_slot), .misalign_err(misalign_err),
      .slot_violation(slot_violation)
   );

   pc_sequencer #(.DELAY_SLOT(1'b0)) dut_z (
      .clk(clk), .rst_n(rst_n), .stall(z_stall),
      .jump_valid(z_jump_valid), .jump_target(z_jump_target),
      .branch_valid(1'b0), .branch_offset(16'h0000),
      .jr_valid(z_jr_valid), .jr_target(z_jr_target),
      .pc(z_pc), .pc_plus4(z_pc_plus4), .pc_upper(z_pc_upper),
      .in_delay_slot(z_in_delay_slot), .misalign_err(z_misalign_err),
      .slot_violation(z_slot_violation)
   );

   typedef struct {
      logic        stall;
      logic        jv;
      logic [31:0] jt;
      logic        bv;
      logic [15:0] bo;
      logic        jrv;
      logic [31:0] jrt;
      logic [31:0] pc;
      logic        slot;
      logic        mis;
      logic        viol;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic st, logic jv, logic [31:0] jt, logic bv, logic [15:0] bo,
                               logic jrv, logic [31:0] jrt, logic [31:0] epc,
                               logic eslot, logic emis, logic eviol);
      vec_t v;
      v.stall = st; v.jv = jv; v.jt = jt; v.bv = bv; v.bo = bo;
      v.jrv = jrv; v.jrt = jrt; v.pc = epc; v.slot = eslot; v.mis = emis; v.viol = eviol;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      stall = 1'b0; jump_valid = 1'b0; jump_target = '0;
      branch_valid = 1'b0; branch_offset = '0; jr_valid = 1'b0; jr_target = '0;
   endtask

   initial begin
      logic [31:0] exp_p4;
      rst_n = 1'b0;
      idle_inputs();
      z_stall = 1'b1; z_jump_valid = 1'b0; z_jump_target = '0;
      z_jr_valid = 1'b0; z_jr_target = '0;

      // stall jv  jt            bv  bo        jrv jrt           pc            slot mis viol
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0004, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0008, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_000C, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0010, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h0000_0100,  0, 16'h0,    0, 32'h0,          32'h0000_0014, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0100, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h0000_0023,  0, 16'h0,    0, 32'h0,          32'h0000_0104, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0020, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          1, 16'hFFFE, 0, 32'h0,          32'h0000_0024, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_001C, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h0000_0800,  1, 16'h0010, 1, 32'h0000_0400,  32'h0000_0020, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0400, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    1, 32'h0000_0402,  32'h0000_0404, 1, 1, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0080, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    1, 32'h0FFF_FFF8,  32'h0000_0084, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0FFF_FFF8, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0FFF_FFFC, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h1000_0000, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h0000_0200,  0, 16'h0,    0, 32'h0,          32'h1000_0004, 1, 0, 0));
      vq.push_back(mk(1, 1, 32'h0000_0300,  0, 16'h0,    0, 32'h0,          32'h1000_0004, 1, 0, 0));
      vq.push_back(mk(1, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h1000_0004, 1, 0, 0));
      vq.push_back(mk(1, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h1000_0004, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0200, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          1, 16'h0004, 0, 32'h0,          32'h0000_0204, 1, 0, 0));
      vq.push_back(mk(0, 1, 32'h0000_0500,  0, 16'h0,    0, 32'h0,          32'h0000_0214, 0, 0, 1));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0218, 0, 0, 0));
      vq.push_back(mk(1, 0, 32'h0,          0, 16'h0,    1, 32'h0000_0003,  32'h0000_0218, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    1, 32'hFFFF_FFFC,  32'h0000_021C, 1, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'hFFFF_FFFC, 0, 0, 0));
      vq.push_back(mk(0, 0, 32'h0,          0, 16'h0,    0, 32'h0,          32'h0000_0000, 0, 0, 0));

      // Reset state
      #12;
      check("reset pc", pc, 32'h0);
      check("reset in_delay_slot", {31'b0, in_delay_slot}, 32'h0);
      check("reset misalign_err", {31'b0, misalign_err}, 32'h0);
      check("reset slot_violation", {31'b0, slot_violation}, 32'h0);
      check("reset pc_upper", {28'b0, pc_upper}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         stall = vq[i].stall; jump_valid = vq[i].jv; jump_target = vq[i].jt;
         branch_valid = vq[i].bv; branch_offset = vq[i].bo;
         jr_valid = vq[i].jrv; jr_target = vq[i].jrt;
         @(posedge clk); #1;
         exp_p4 = vq[i].pc + 32'd4;
         $display("vec %0d: pc=%h slot=%0d mis=%0d viol=%0d", i, pc, in_delay_slot, misalign_err, slot_violation);
         check($sformatf("vec%0d pc", i), pc, vq[i].pc);
         check($sformatf("vec%0d in_delay_slot", i), {31'b0, in_delay_slot}, {31'b0, vq[i].slot});
         check($sformatf("vec%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vq[i].mis});
         check($sformatf("vec%0d slot_violation", i), {31'b0, slot_violation}, {31'b0, vq[i].viol});
         check($sformatf("vec%0d pc_plus4", i), pc_plus4, exp_p4);
         check($sformatf("vec%0d pc_upper", i), {28'b0, pc_upper}, {28'b0, exp_p4[31:28]});
      end

      // Reset in the middle of a delay slot drops the pending target
      idle_inputs();
      jump_valid = 1'b1; jump_target = 32'h0000_0600;
      @(posedge clk); #1;
      $display("rst-mid-slot setup: pc=%h slot=%0d", pc, in_delay_slot);
      check("midslot pre pc", pc, 32'h0000_0004);
      check("midslot pre in_delay_slot", {31'b0, in_delay_slot}, 32'h1);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      $display("rst-mid-slot async: pc=%h slot=%0d", pc, in_delay_slot);
      check("midslot async pc", pc, 32'h0);
      check("midslot async in_delay_slot", {31'b0, in_delay_slot}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("rst-mid-slot after: pc=%h slot=%0d", pc, in_delay_slot);
      check("midslot after pc", pc, 32'h0000_0004);
      check("midslot after in_delay_slot", {31'b0, in_delay_slot}, 32'h0);

      // No-delay-slot instance: redirects land on the next edge
      z_stall = 1'b0; z_jump_valid = 1'b1; z_jump_target = 32'h0000_0040;
      @(posedge clk); #1;
      $display("z jump: pc=%h slot=%0d", z_pc, z_in_delay_slot);
      check("z jump pc", z_pc, 32'h0000_0040);
      check("z jump in_delay_slot", {31'b0, z_in_delay_slot}, 32'h0);
      z_jump_valid = 1'b0; z_jr_valid = 1'b1; z_jr_target = 32'h0000_0041;
      @(posedge clk); #1;
      $display("z jr misaligned: pc=%h mis=%0d", z_pc, z_misalign_err);
      check("z misjr pc", z_pc, 32'h0000_0080);
      check("z misjr misalign_err", {31'b0, z_misalign_err}, 32'h1);
      z_jr_valid = 1'b0;
      @(posedge clk); #1;
      $display("z seq: pc=%h mis=%0d", z_pc, z_misalign_err);
      check("z seq pc", z_pc, 32'h0000_0084);
      check("z seq misalign_err", {31'b0, z_misalign_err}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
